// File: rtl/sram_dma_engine_if.sv
// Bus bundle between the DMA engine and its surroundings: CPU DMA command port,
// scratch SRAM port and the external DRAM request/valid port.
interface sram_dma_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 10,
    parameter int SRAM_AW    = 14
);
    logic [1:0]            dmaCmd;
    logic [ADDR_WIDTH-1:0] dmaSrcAddress;
    logic [ADDR_WIDTH-1:0] dmaDstAddress;
    logic [LEN_WIDTH-1:0]  dmaWidth;
    logic                  stall;

    logic [SRAM_AW-1:0]    sramAddr;
    logic                  sramWriteEnable;
    logic [DATA_WIDTH-1:0] sramWriteData;
    logic [DATA_WIDTH-1:0] sramReadData;

    logic                  dramReq;
    logic                  dramWe;
    logic [ADDR_WIDTH-1:0] dramAddr;
    logic [DATA_WIDTH-1:0] dramWData;
    logic                  dramReady;
    logic                  dramRValid;
    logic [DATA_WIDTH-1:0] dramRData;

    // The engine side drives the memories and the stall line.
    modport master (
        input  dmaCmd, dmaSrcAddress, dmaDstAddress, dmaWidth,
        input  sramReadData, dramReady, dramRValid, dramRData,
        output stall, sramAddr, sramWriteEnable, sramWriteData,
        output dramReq, dramWe, dramAddr, dramWData
    );

    modport slave (
        output dmaCmd, dmaSrcAddress, dmaDstAddress, dmaWidth,
        output sramReadData, dramReady, dramRValid, dramRData,
        input  stall, sramAddr, sramWriteEnable, sramWriteData,
        input  dramReq, dramWe, dramAddr, dramWData
    );
endinterface

// File: rtl/sram_dma_engine.sv
// Block-copy DMA engine between scratch SRAM and external DRAM (either direction);
// holds the CPU pipeline stalled until the copy has completed.
module sram_dma_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 10,
    parameter int SRAM_AW    = 14
) (
    input  logic              clk,
    input  logic              reset,
    sram_dma_engine_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, D2S_REQ, D2S_WAIT, D2S_WRITE, S2D_READ, S2D_LATCH, S2D_REQ, DONE
    } state_e;

    localparam logic [1:0]            CMD_D2S    = 2'b01;
    localparam logic [1:0]            CMD_S2D    = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(4);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  last_word;

    assign last_word = (rem_q == LEN_WIDTH'(1));

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
        end
    end

    // NOTE: every next-state value and output gets a default first, so no path infers a latch.
    always_comb begin
        state_d             = state_q;
        src_d               = src_q;
        dst_d               = dst_q;
        rem_d               = rem_q;
        buf_d               = buf_q;
        bus.stall           = 1'b0;
        bus.sramAddr        = '0;
        bus.sramWriteEnable = 1'b0;
        bus.sramWriteData   = '0;
        bus.dramReq         = 1'b0;
        bus.dramWe          = 1'b0;
        bus.dramAddr        = '0;
        bus.dramWData       = '0;

        case (state_q)
            IDLE: begin
                // Command 11 is reserved and falls through as a no-op.
                if (bus.dmaCmd == CMD_D2S || bus.dmaCmd == CMD_S2D) begin
                    bus.stall = 1'b1;
                    src_d     = bus.dmaSrcAddress;
                    dst_d     = bus.dmaDstAddress;
                    rem_d     = bus.dmaWidth;
                    if (bus.dmaWidth == '0)        state_d = DONE;
                    else if (bus.dmaCmd == CMD_D2S) state_d = D2S_REQ;
                    else                            state_d = S2D_READ;
                end
            end
            D2S_REQ: begin
                bus.stall    = 1'b1;
                bus.dramReq  = 1'b1;
                bus.dramAddr = src_q;
                if (bus.dramReady) state_d = D2S_WAIT;
            end
            D2S_WAIT: begin
                bus.stall = 1'b1;
                if (bus.dramRValid) begin
                    buf_d   = bus.dramRData;
                    state_d = D2S_WRITE;
                end
            end
            D2S_WRITE: begin
                bus.stall           = 1'b1;
                bus.sramWriteEnable = 1'b1;
                bus.sramAddr        = dst_q[SRAM_AW+1:2];
                bus.sramWriteData   = buf_q;
                src_d               = src_q + WORD_BYTES;
                dst_d               = dst_q + WORD_BYTES;
                rem_d               = rem_q - LEN_WIDTH'(1);
                state_d             = last_word ? DONE : D2S_REQ;
            end
            S2D_READ: begin
                bus.stall    = 1'b1;
                bus.sramAddr = src_q[SRAM_AW+1:2];
                state_d      = S2D_LATCH;
            end
            S2D_LATCH: begin
                // SRAM data for the address presented last cycle is valid now.
                bus.stall = 1'b1;
                buf_d     = bus.sramReadData;
                state_d   = S2D_REQ;
            end
            S2D_REQ: begin
                bus.stall     = 1'b1;
                bus.dramReq   = 1'b1;
                bus.dramWe    = 1'b1;
                bus.dramAddr  = dst_q;
                bus.dramWData = buf_q;
                if (bus.dramReady) begin
                    src_d   = src_q + WORD_BYTES;
                    dst_d   = dst_q + WORD_BYTES;
                    rem_d   = rem_q - LEN_WIDTH'(1);
                    state_d = last_word ? DONE : S2D_READ;
                end
            end
            DONE: begin
                // Stall drops for this single cycle while the CPU retires the instruction.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sram_dma_engine.sv
// Self-checking bench for sram_dma_engine: SRAM/DRAM behavioural models feed
// observed-write queues that each scenario task compares against its expectations.
module tb_sram_dma_engine;
    localparam int AW           = 32;
    localparam int DW           = 32;
    localparam int LW           = 10;
    localparam int SAW          = 14;
    localparam int RD_LATENCY   = 2;
    localparam int STALL_BUDGET = 400;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_dma_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .SRAM_AW(SAW)) bus ();

    sram_dma_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .SRAM_AW(SAW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed { logic [SAW-1:0] idx;  logic [DW-1:0] data; } sram_wr_t;
    typedef struct packed { logic [AW-1:0]  addr; logic [DW-1:0] data; } dram_wr_t;

    sram_wr_t sram_exp[$];
    sram_wr_t sram_obs[$];
    dram_wr_t dram_exp[$];
    dram_wr_t dram_obs[$];

    logic [DW-1:0]  sram_mem [0:(1<<SAW)-1];
    logic [SAW-1:0] sram_rd_addr = '0;

    int n_checks = 0;
    int n_pass   = 0;

    bit            rd_pending = 1'b0;
    int            rd_cnt     = 0;
    logic [AW-1:0] rd_addr    = '0;
    int            rd_accepts = 0;
    int            wr_accepts = 0;
    int            hold_word  = -1;
    int            hold_left  = 0;
    int            low_cycles = 0;
    int            stable_err = 0;
    int            req_seen   = 0;
    bit            wr_waiting = 1'b0;
    logic [AW-1:0] held_addr  = '0;
    logic [DW-1:0] held_data  = '0;

    function automatic logic [DW-1:0] dram_word(input logic [AW-1:0] a);
        return 32'hA0 + ((a - 32'h100) >> 2);
    endfunction

    // Memory models: everything observed on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            rd_pending     = 1'b0;
            wr_waiting     = 1'b0;
            bus.dramRValid = 1'b0;
            bus.dramReady  = 1'b1;
        end else begin
            bus.dramRValid = 1'b0;
            if (rd_pending) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    bus.dramRValid = 1'b1;
                    bus.dramRData  = dram_word(rd_addr);
                    rd_pending     = 1'b0;
                end
            end
            if (bus.dramReq) req_seen++;
            if (bus.dramReq && bus.dramWe) begin
                if (wr_waiting && (bus.dramAddr !== held_addr || bus.dramWData !== held_data))
                    stable_err++;
                held_addr = bus.dramAddr;
                held_data = bus.dramWData;
                if (wr_accepts == hold_word && hold_left > 0) begin
                    bus.dramReady = 1'b0;
                    hold_left--;
                    low_cycles++;
                end else begin
                    bus.dramReady = 1'b1;
                end
            end else begin
                bus.dramReady = 1'b1;
            end
            wr_waiting = bus.dramReq && bus.dramWe && !bus.dramReady;
            if (bus.dramReq && bus.dramReady) begin
                if (bus.dramWe) begin
                    dram_obs.push_back({bus.dramAddr, bus.dramWData});
                    wr_accepts++;
                end else begin
                    rd_pending = 1'b1;
                    rd_cnt     = RD_LATENCY;
                    rd_addr    = bus.dramAddr;
                    rd_accepts++;
                end
            end
            if (bus.sramWriteEnable) begin
                sram_mem[bus.sramAddr] = bus.sramWriteData;
                sram_obs.push_back({bus.sramAddr, bus.sramWriteData});
            end
            sram_rd_addr = bus.sramAddr;
        end
    end

    // Synchronous SRAM read: data for the address seen this cycle appears after the edge.
    always @(posedge clk) begin
        #1;
        bus.sramReadData = sram_mem[sram_rd_addr];
    end

    // Issue one command and count the cycles stall stays high (first IDLE cycle included).
    task automatic run_cmd(input logic [1:0] cmd, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input logic [LW-1:0] width, output int cycles);
        @(negedge clk); #1;
        bus.dmaCmd        = cmd;
        bus.dmaSrcAddress = src;
        bus.dmaDstAddress = dst;
        bus.dmaWidth      = width;
        #1;
        cycles = 0;
        while (bus.stall === 1'b1 && cycles < STALL_BUDGET) begin
            cycles++;
            @(negedge clk); #1;
            bus.dmaCmd        = 2'b00;
            bus.dmaSrcAddress = 32'hDEAD_0000;
            bus.dmaDstAddress = 32'hBEEF_0000;
            bus.dmaWidth      = 10'h3FF;
            #1;
        end
        n_checks++;
        if (cycles >= STALL_BUDGET) $display("FAIL cmd_timeout: stall still high after %0d cycles", cycles);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (bus.stall !== 1'b0) $display("FAIL cmd_back_to_idle: stall=%b expected 0", bus.stall);
        else n_pass++;
    endtask

    task automatic test_reset;
        reset                 = 1'b1;
        bus.dmaCmd            = 2'b00;
        bus.dmaSrcAddress     = '0;
        bus.dmaDstAddress     = '0;
        bus.dmaWidth          = '0;
        bus.sramReadData      = '0;
        bus.dramReady         = 1'b1;
        bus.dramRValid        = 1'b0;
        bus.dramRData         = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({bus.stall, bus.dramReq, bus.dramWe, bus.sramWriteEnable} !== 4'b0000)
            $display("FAIL reset_ctrl: stall/req/we/sram_we=%b expected 0000",
                     {bus.stall, bus.dramReq, bus.dramWe, bus.sramWriteEnable});
        else n_pass++;
        n_checks++;
        if ({bus.dramAddr, bus.dramWData} !== 64'h0)
            $display("FAIL reset_dram_bus: addr=%h wdata=%h expected 0", bus.dramAddr, bus.dramWData);
        else n_pass++;
        n_checks++;
        if ({bus.sramAddr, bus.sramWriteData} !== '0)
            $display("FAIL reset_sram_bus: addr=%h wdata=%h expected 0", bus.sramAddr, bus.sramWriteData);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (bus.stall !== 1'b0) $display("FAIL reset_idle_stall: stall=%b expected 0", bus.stall);
        else n_pass++;
    endtask

    task automatic test_d2s;
        int cyc;
        sram_wr_t e, o;
        sram_obs.delete();
        req_seen = 0;
        for (int i = 0; i < 4; i++)
            sram_exp.push_back({SAW'(16 + i), DW'(32'hA0 + i)});
        run_cmd(2'b01, 32'h100, 32'h40, 10'd4, cyc);
        n_checks++;
        if (cyc !== 17) $display("FAIL d2s_stall_cycles: got %0d expected 17", cyc);
        else n_pass++;
        while (sram_exp.size() > 0) begin
            e = sram_exp.pop_front();
            n_checks++;
            if (sram_obs.size() == 0) begin
                $display("FAIL d2s_sram_write: missing, expected idx %0d data %h", e.idx, e.data);
            end else begin
                o = sram_obs.pop_front();
                if (o !== e) $display("FAIL d2s_sram_write: got idx %0d data %h expected idx %0d data %h",
                                      o.idx, o.data, e.idx, e.data);
                else n_pass++;
            end
        end
        n_checks++;
        if (sram_obs.size() != 0) $display("FAIL d2s_extra_writes: %0d extra expected 0", sram_obs.size());
        else n_pass++;
        n_checks++;
        if (req_seen !== 4) $display("FAIL d2s_req_cycles: got %0d expected 4", req_seen);
        else n_pass++;
    endtask

    task automatic test_s2d;
        int cyc;
        dram_wr_t e, o;
        dram_obs.delete();
        sram_mem[0] = 32'd5;
        sram_mem[1] = 32'd6;
        sram_mem[2] = 32'd7;
        wr_accepts  = 0;
        hold_word   = 1;
        hold_left   = 3;
        low_cycles  = 0;
        stable_err  = 0;
        for (int i = 0; i < 3; i++)
            dram_exp.push_back({AW'(32'h2000 + 4 * i), DW'(5 + i)});
        run_cmd(2'b10, 32'h0, 32'h2000, 10'd3, cyc);
        hold_word = -1;
        n_checks++;
        if (cyc !== 13) $display("FAIL s2d_stall_cycles: got %0d expected 13", cyc);
        else n_pass++;
        while (dram_exp.size() > 0) begin
            e = dram_exp.pop_front();
            n_checks++;
            if (dram_obs.size() == 0) begin
                $display("FAIL s2d_dram_write: missing, expected addr %h data %h", e.addr, e.data);
            end else begin
                o = dram_obs.pop_front();
                if (o !== e) $display("FAIL s2d_dram_write: got addr %h data %h expected addr %h data %h",
                                      o.addr, o.data, e.addr, e.data);
                else n_pass++;
            end
        end
        n_checks++;
        if (dram_obs.size() != 0) $display("FAIL s2d_extra_writes: %0d extra expected 0", dram_obs.size());
        else n_pass++;
        n_checks++;
        if (low_cycles !== 3) $display("FAIL s2d_ready_low_cycles: got %0d expected 3", low_cycles);
        else n_pass++;
        n_checks++;
        if (stable_err !== 0) $display("FAIL s2d_req_stable: %0d changes while waiting expected 0", stable_err);
        else n_pass++;
    endtask

    task automatic test_zero_and_reserved;
        int cyc;
        int stall_hi;
        sram_obs.delete();
        req_seen = 0;
        run_cmd(2'b01, 32'h100, 32'h40, 10'd0, cyc);
        n_checks++;
        if (cyc !== 1) $display("FAIL zero_len_stall_cycles: got %0d expected 1", cyc);
        else n_pass++;
        n_checks++;
        if (req_seen !== 0 || sram_obs.size() != 0)
            $display("FAIL zero_len_activity: dram_req cycles %0d sram writes %0d expected 0 and 0",
                     req_seen, sram_obs.size());
        else n_pass++;
        stall_hi = 0;
        @(negedge clk); #1;
        bus.dmaCmd   = 2'b11;
        bus.dmaWidth = 10'd4;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.stall !== 1'b0) stall_hi++;
            @(negedge clk); #1;
        end
        bus.dmaCmd = 2'b00;
        n_checks++;
        if (stall_hi !== 0 || req_seen !== 0 || sram_obs.size() != 0)
            $display("FAIL reserved_cmd: stall cycles %0d req %0d writes %0d expected all 0",
                     stall_hi, req_seen, sram_obs.size());
        else n_pass++;
    endtask

    task automatic test_sram_wrap;
        int cyc;
        sram_wr_t e, o;
        sram_obs.delete();
        sram_exp.push_back({SAW'((1 << SAW) - 1), dram_word(32'h200)});
        sram_exp.push_back({SAW'(0), dram_word(32'h204)});
        run_cmd(2'b01, 32'h200, AW'(((1 << SAW) - 1) * 4), 10'd2, cyc);
        n_checks++;
        if (cyc !== 9) $display("FAIL wrap_stall_cycles: got %0d expected 9", cyc);
        else n_pass++;
        while (sram_exp.size() > 0) begin
            e = sram_exp.pop_front();
            n_checks++;
            if (sram_obs.size() == 0) begin
                $display("FAIL wrap_sram_write: missing, expected idx %0d data %h", e.idx, e.data);
            end else begin
                o = sram_obs.pop_front();
                if (o !== e) $display("FAIL wrap_sram_write: got idx %0d data %h expected idx %0d data %h",
                                      o.idx, o.data, e.idx, e.data);
                else n_pass++;
            end
        end
        n_checks++;
        if (sram_obs.size() != 0) $display("FAIL wrap_extra_writes: %0d extra expected 0", sram_obs.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_transfer;
        int cyc;
        int n;
        sram_wr_t e, o;
        sram_obs.delete();
        rd_accepts = 0;
        sram_exp.push_back({SAW'(32), dram_word(32'h300)});
        @(negedge clk); #1;
        bus.dmaCmd        = 2'b01;
        bus.dmaSrcAddress = 32'h300;
        bus.dmaDstAddress = 32'h80;
        bus.dmaWidth      = 10'd4;
        n = 0;
        while (rd_accepts < 2 && n < 100) begin
            @(negedge clk); #1;
            bus.dmaCmd = 2'b00;
            n++;
        end
        n_checks++;
        if (rd_accepts < 2) $display("FAIL reset_reach_word2: read accepts %0d expected 2", rd_accepts);
        else n_pass++;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.stall, bus.dramReq, bus.sramWriteEnable} !== 3'b000)
            $display("FAIL reset_async_clear: stall/req/sram_we=%b expected 000",
                     {bus.stall, bus.dramReq, bus.sramWriteEnable});
        else n_pass++;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk); #1;
        bus.dramRValid = 1'b1;
        bus.dramRData  = 32'hDEAD_BEEF;
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (bus.stall !== 1'b0) $display("FAIL reset_stray_rvalid_stall: stall=%b expected 0", bus.stall);
        else n_pass++;
        e = sram_exp.pop_front();
        n_checks++;
        if (sram_obs.size() != 1) begin
            $display("FAIL reset_sram_writes: got %0d writes expected 1", sram_obs.size());
        end else begin
            o = sram_obs.pop_front();
            if (o !== e) $display("FAIL reset_sram_writes: got idx %0d data %h expected idx %0d data %h",
                                  o.idx, o.data, e.idx, e.data);
            else n_pass++;
        end
        sram_obs.delete();
        e = {SAW'(4), dram_word(32'h100)};
        run_cmd(2'b01, 32'h100, 32'h10, 10'd1, cyc);
        n_checks++;
        if (cyc !== 5) $display("FAIL after_reset_stall_cycles: got %0d expected 5", cyc);
        else n_pass++;
        n_checks++;
        if (sram_obs.size() != 1) begin
            $display("FAIL after_reset_write: got %0d writes expected 1", sram_obs.size());
        end else begin
            o = sram_obs.pop_front();
            if (o !== e) $display("FAIL after_reset_write: got idx %0d data %h expected idx %0d data %h",
                                  o.idx, o.data, e.idx, e.data);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_d2s();
        test_s2d();
        test_zero_and_reserved();
        test_sram_wrap();
        test_reset_mid_transfer();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sram_dma_engine.md
Name: sram_dma_engine

Overview:
- Parametrised DMA engine between the CPU's DMA command port and two memories: the on-chip scratch SRAM and an external DRAM with a request/valid handshake.
- Executes block copies in either direction (DRAM->SRAM, SRAM->DRAM) and holds the pipeline stalled until the copy completes.
- Sits beside the pipelined CPU and SRAM in the top-level SoC wrapper. It replaces direct CPU-to-SRAM DMA wiring.

Parameters:
- ADDR_WIDTH, 32: byte-address width of the DMA source/destination and the DRAM address.
- DATA_WIDTH, 32: word width on SRAM and DRAM data buses.
- LEN_WIDTH, 10: width of dmaWidth, the transfer length in words.
- SRAM_AW, 14: SRAM word-address width. The SRAM address is byte address bits [SRAM_AW+1:2].

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- dmaCmd  in  2  00 none, 01 d2s (DRAM->SRAM), 10 s2d (SRAM->DRAM), 11 reserved
- dmaSrcAddress  in  ADDR_WIDTH  source byte address, word aligned
- dmaDstAddress  in  ADDR_WIDTH  destination byte address, word aligned
- dmaWidth  in  LEN_WIDTH  transfer length in words
- stall  out  1  pipeline stall request
- sramAddr  out  SRAM_AW  SRAM word address
- sramWriteEnable  out  1  SRAM write strobe
- sramWriteData  out  DATA_WIDTH  SRAM write data
- sramReadData  in  DATA_WIDTH  SRAM read data; one-cycle synchronous read latency
- dramReq  out  1  DRAM request valid
- dramWe  out  1  1 = write request, 0 = read request
- dramAddr  out  ADDR_WIDTH  DRAM byte address
- dramWData  out  DATA_WIDTH  DRAM write data
- dramReady  in  1  DRAM accepts the request on this edge when dramReq is also high
- dramRValid  in  1  read data valid
- dramRData  in  DATA_WIDTH  read data

Behaviour:
- Reset (asynchronous):
  - State IDLE.
  - All outputs 0.
  - Counters and address registers cleared.
  - In-flight DRAM request abandoned.
  - dramRValid is ignored outside D2S_WAIT.
- States: IDLE, D2S_REQ, D2S_WAIT, D2S_WRITE, S2D_READ, S2D_LATCH, S2D_REQ, DONE.
- IDLE:
  - dmaCmd is sampled only in IDLE.
  - 01 or 10: stall=1 combinationally in the same cycle. srcPtr, dstPtr and remaining are loaded from the ports.
  - Next state is D2S_REQ / S2D_READ, or DONE if dmaWidth==0.
  - 00 or 11: no stall, stay IDLE. 11 is silently ignored.
- D2S_REQ: dramReq=1, dramWe=0, dramAddr=srcPtr. Hold until dramReady, then go to D2S_WAIT.
- D2S_WAIT: wait for dramRValid and capture dramRData into the data buffer, then go to D2S_WRITE.
- D2S_WRITE:
  - sramWriteEnable=1, sramAddr=dstPtr[SRAM_AW+1:2], sramWriteData=buffer.
  - srcPtr+=4, dstPtr+=4, remaining-=1.
  - Next state is D2S_REQ, or DONE if remaining was 1.
- S2D_READ: sramAddr=srcPtr[SRAM_AW+1:2]; go to S2D_LATCH.
- S2D_LATCH: capture sramReadData into the buffer; go to S2D_REQ.
- S2D_REQ:
  - dramReq=1, dramWe=1, dramAddr=dstPtr, dramWData=buffer. Request fields are held stable until dramReady.
  - On acceptance: pointers +=4, remaining -=1. Next state is S2D_READ, or DONE.
- DONE: stall=0 for exactly one cycle (the CPU retires the DMA instruction on this edge), then IDLE unconditionally. The same command is never re-executed.
- stall = (state != IDLE && state != DONE) || (state == IDLE && (dmaCmd == 01 || dmaCmd == 10)).
- Outputs not named for a state are 0.
- Arithmetic and wrap-around:
  - Pointers are modulo 2^ADDR_WIDTH.
  - The SRAM index wraps modulo 2^SRAM_AW. Upper address bits are ignored.
  - remaining is LEN_WIDTH bits, so the maximum transfer is 2^LEN_WIDTH-1 words.
- Inputs dmaSrcAddress/dmaDstAddress/dmaWidth are ignored after IDLE; changes mid-transfer have no effect.
- Timing:
  - d2s word cost: 1 (REQ, with ready=1) + L (cycles until rvalid) + 1 (WRITE).
  - s2d word cost: 3 cycles with ready=1.

Test Plan:
- d2s, src=0x100, dst=0x40, width=4; DRAM ready=1, rvalid exactly 2 cycles after acceptance, data 0xA0..0xA3 -> SRAM words 16..19 = A0..A3; stall high for 1+4*4=17 cycles, then low 1 cycle (DONE), back to IDLE.
- s2d, src=0x0, dst=0x2000, width=3, SRAM[0..2]=5,6,7; dramReady held low 3 cycles on the second word -> DRAM writes (0x2000,5), (0x2004,6), (0x2008,7); dramAddr and dramWData stable while waiting; stall=1+3*3+3=13 cycles.
- width=0 with cmd=01 -> stall high exactly 1 cycle; no dramReq, no sramWriteEnable. cmd=11 -> stall never asserted, state stays IDLE.
- SRAM wrap: d2s with dst=(2^SRAM_AW-1)*4, width=2 -> writes at SRAM index 2^SRAM_AW-1 then index 0.
- Reset asserted asynchronously during D2S_WAIT of word 2 of 4 -> stall, dramReq and sramWriteEnable go 0 immediately; a later dramRValid pulse causes no SRAM write; a new cmd=01 width=1 then completes normally.
